// File: rtl/writeback_arbiter_if.sv
// Writeback bus: producer-side result channels plus the register-file write port
// and the hazard-facing pending/empty status.
interface writeback_arbiter_if #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) ();

  localparam int unsigned NREGS = 2 ** REG_ADDR_W;

  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS-1:0]            in_ready;
  logic [CHANNELS-1:0]            in_reg_we;
  logic [CHANNELS*REG_ADDR_W-1:0] in_target;
  logic [CHANNELS*DATA_W-1:0]     in_value;

  logic [REG_ADDR_W-1:0]          reg_a_write;
  logic                           reg_we;
  logic [DATA_W-1:0]              reg_write;

  logic [NREGS-1:0]               pending;
  logic                           empty;

  modport master (
    output in_valid, in_reg_we, in_target, in_value,
    input  in_ready, reg_a_write, reg_we, reg_write, pending, empty
  );

  modport slave (
    input  in_valid, in_reg_we, in_target, in_value,
    output in_ready, reg_a_write, reg_we, reg_write, pending, empty
  );

endinterface

// File: rtl/writeback_arbiter.sv
// Per-channel result FIFOs feeding one register-file write port through a
// round-robin arbiter; exports a pending-write mask for the hazard unit.
module writeback_arbiter #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  writeback_arbiter_if.slave wb
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned NREGS = 2 ** REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] target;
    logic [DATA_W-1:0]     value;
  } entry_t;

  entry_t              mem    [CHANNELS][FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr [CHANNELS];
  logic [PTR_W-1:0]    wr_ptr [CHANNELS];
  logic [CNT_W-1:0]    count  [CHANNELS];
  logic [CH_W-1:0]     rr_ptr;

  entry_t              in_entry [CHANNELS];
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] nonempty;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic                grant_valid;
  logic [CH_W-1:0]     grant_idx;
  logic [CH_W-1:0]     rr_next;
  entry_t              grant_entry;
  logic [NREGS-1:0]    pend;

  // FIFO status and input unpacking; ready depends on registered occupancy only
  always_comb begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      full[k]            = (count[k] == CNT_W'(FIFO_DEPTH));
      nonempty[k]        = (count[k] != '0);
      in_entry[k].target = wb.in_target[k*REG_ADDR_W +: REG_ADDR_W];
      in_entry[k].value  = wb.in_value[k*DATA_W +: DATA_W];
    end
  end

  // Accepted results with no register side effect are dropped here
  always_comb begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      push[k] = wb.in_valid[k] && !full[k] && wb.in_reg_we[k] &&
                (in_entry[k].target != '0);
    end
  end

  assign wb.in_ready = ~full;

  // Round-robin search starting at rr_ptr
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = (32'(rr_ptr) + i) % CHANNELS;
      if (!grant_valid && nonempty[CH_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      pop[k] = grant_valid && (grant_idx == CH_W'(k));
    end
  end

  assign grant_entry = mem[grant_idx][rd_ptr[grant_idx]];
  assign rr_next     = (32'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + CH_W'(1);

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (push[k]) begin
          wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
        end
        if (pop[k]) begin
          rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
        end
        if (push[k] && !pop[k]) begin
          count[k] <= count[k] + CNT_W'(1);
        end else if (pop[k] && !push[k]) begin
          count[k] <= count[k] - CNT_W'(1);
        end
      end
    end
  end

  // Payload storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (push[k]) begin
        mem[k][wr_ptr[k]] <= in_entry[k];
      end
    end
  end

  // Register-file write port and arbitration pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      wb.reg_we      <= 1'b0;
      wb.reg_a_write <= '0;
      wb.reg_write   <= '0;
    end else if (grant_valid) begin
      rr_ptr         <= rr_next;
      wb.reg_we      <= 1'b1;
      wb.reg_a_write <= grant_entry.target;
      wb.reg_write   <= grant_entry.value;
    end else begin
      wb.reg_we      <= 1'b0;
    end
  end

  // Pending mask: every occupied FIFO slot plus the write being presented
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot = '0;
    pend = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
        slot = rd_ptr[k] + PTR_W'(j);
        if (CNT_W'(j) < count[k]) begin
          pend[mem[k][slot].target] = 1'b1;
        end
      end
    end
    if (wb.reg_we) begin
      pend[wb.reg_a_write] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign wb.pending = pend;
  assign wb.empty   = !(|nonempty) && !wb.reg_we;

endmodule
